// File: rtl/mips_muldiv_if.sv
// Handshake and operand/result bundle between the pipeline control and the
// MIPS multiply/divide unit.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic          clk,
    input logic          rst_n,
    mips_muldiv_if.slave bus
);
    localparam logic [2:0] OP_MULTU = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_DIVU  = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t               state, state_next;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     m;
    logic [CNT_W-1:0]     count;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 is_div;
    logic                 b_zero;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 done_q, dbz_q;

    logic                 accept;
    logic                 signed_op;
    logic                 sign_a, sign_b;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 last_step;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       trial;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     rem_fix, quot_fix;

    assign accept    = (state == IDLE) && bus.start && !bus.flush;
    assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign sign_a    = signed_op && bus.a[WIDTH-1];
    assign sign_b    = signed_op && bus.b[WIDTH-1];
    assign a_mag     = sign_a ? -bus.a : bus.a;
    assign b_mag     = sign_b ? -bus.b : bus.b;
    assign last_step = (count == CNT_W'(WIDTH - 1));

    // Multiply: upper half accumulates the multiplicand, lower half holds
    // the multiplier bits still to be consumed; shift right every step.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts the
    // dividend out and the quotient bits in.
    assign rem_shift = acc[2*WIDTH-1:WIDTH-1];
    assign trial     = rem_shift - {1'b0, m};
    assign div_next  = trial[WIDTH]
                     ? {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                     : {trial[WIDTH-1:0],     acc[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_res ? -acc : acc;
    assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: next state is defaulted first so no path through the case
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MULTU || bus.op == OP_MULT)    state_next = MUL;
                    else if (bus.op == OP_DIVU || bus.op == OP_DIV) state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (bus.flush)     state_next = IDLE;
                else if (last_step) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            m       <= '0;
            count   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
            b_zero  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        count <= '0;
                        case (bus.op)
                            OP_MULTU, OP_MULT: begin
                                acc     <= {{WIDTH{1'b0}}, b_mag};
                                m       <= a_mag;
                                neg_res <= sign_a ^ sign_b;
                                neg_rem <= 1'b0;
                                is_div  <= 1'b0;
                                b_zero  <= 1'b0;
                            end
                            OP_DIVU, OP_DIV: begin
                                acc     <= {{WIDTH{1'b0}}, a_mag};
                                m       <= b_mag;
                                neg_res <= sign_a ^ sign_b;
                                neg_rem <= sign_a;
                                is_div  <= 1'b1;
                                b_zero  <= (bus.b == '0);
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count + CNT_W'(1);
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count + CNT_W'(1);
                end
                FIX: begin
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (is_div) begin
                            // With a zero divisor the remainder path rebuilds
                            // the original dividend; the quotient is all ones.
                            hi_q  <= rem_fix;
                            lo_q  <= b_zero ? {WIDTH{1'b1}} : quot_fix;
                            dbz_q <= b_zero;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
